// File: rtl/idecode_stage_if.sv
// Fetch/decode boundary: IF/ID instruction in, stall and redirect back.
interface idecode_stage_if;
    logic [31:0] Fetched;
    logic [31:0] FetchedPC;
    logic        Flush;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;

    modport master (
        output Fetched, FetchedPC, Flush,
        input  Stall, BranchTaken, BranchTarget
    );
    modport slave (
        input  Fetched, FetchedPC, Flush,
        output Stall, BranchTaken, BranchTarget
    );
endinterface

// File: rtl/idecode_stage.sv
// MIPS ID stage: decode, hazard stall, branch resolve, ID/EX register.
module idecode_stage (
    input  logic        Clk,
    input  logic        Reset_n,
    idecode_stage_if.slave fetch,
    output logic [4:0]  RsAddr,
    output logic [4:0]  RtAddr,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic [4:0]  MemDest,
    input  logic        MemRegWrite,
    input  logic        MemIsLoad,
    output logic        IdExValid,
    output logic        IdExRegWrite,
    output logic        IdExMemRead,
    output logic        IdExMemWrite,
    output logic        IdExIllegal,
    output logic [5:0]  IdExOp,
    output logic [5:0]  IdExFunct,
    output logic [4:0]  IdExDest,
    output logic [31:0] IdExRsVal,
    output logic [31:0] IdExRtVal,
    output logic [31:0] IdExImm,
    output logic [15:0] StallCount
);
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] ins;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;

    assign ins    = fetch.Fetched;
    assign op     = ins[31:26];
    assign rs     = ins[25:21];
    assign rt     = ins[20:16];
    assign rd     = ins[15:11];
    assign imm    = ins[15:0];
    assign RsAddr = rs;
    assign RtAddr = rt;

    logic       dec_wr, dec_mrd, dec_mwr, dec_ill;
    logic       use_rs, use_rt, is_beq, is_bne, is_j;
    logic [4:0] dec_dest;

    always_comb begin
        dec_wr   = 1'b0;
        dec_mrd  = 1'b0;
        dec_mwr  = 1'b0;
        dec_ill  = 1'b0;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        dec_dest = 5'd0;
        unique case (1'b1)
            op == 6'h00: begin
                dec_dest = rd;
                dec_wr   = (ins != NOP);
                use_rs   = 1'b1;
                use_rt   = 1'b1;
            end
            (op == 6'h08) || (op == 6'h0A) || (op == 6'h0C) ||
            (op == 6'h0D) || (op == 6'h0F): begin
                dec_dest = rt;
                dec_wr   = 1'b1;
                use_rs   = 1'b1;
            end
            op == 6'h23: begin
                dec_dest = rt;
                dec_wr   = 1'b1;
                dec_mrd  = 1'b1;
                use_rs   = 1'b1;
            end
            op == 6'h2B: begin
                dec_mwr = 1'b1;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            op == 6'h04: begin
                is_beq = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            op == 6'h05: begin
                is_bne = 1'b1;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            op == 6'h02: is_j = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    function automatic logic hit(input logic [4:0] src,
                                 input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    logic is_br, load_use, br_haz, stall, eq;
    logic [31:0] pc4, br_off, dec_imm;

    assign is_br    = is_beq | is_bne;
    assign load_use = IdExMemRead &&
                      ((use_rs && hit(rs, IdExDest)) ||
                       (use_rt && hit(rt, IdExDest)));
    // No forwarding into ID: branches wait for EX and in-flight loads.
    assign br_haz   = is_br &&
                      ((IdExRegWrite &&
                        (hit(rs, IdExDest) || hit(rt, IdExDest))) ||
                       (MemIsLoad && MemRegWrite &&
                        (hit(rs, MemDest) || hit(rt, MemDest))));
    assign stall    = !fetch.Flush && (load_use || br_haz);
    assign eq       = (RsData == RtData);

    assign pc4     = fetch.FetchedPC + 32'd4;
    assign br_off  = {{14{imm[15]}}, imm, 2'b00};
    assign dec_imm = (op == 6'h0F) ? {imm, 16'h0000}
                                   : {{16{imm[15]}}, imm};

    assign fetch.Stall        = stall;
    assign fetch.BranchTaken  = !fetch.Flush && !stall &&
                                (is_j || (is_beq && eq) ||
                                 (is_bne && !eq));
    assign fetch.BranchTarget = is_br ? pc4 + br_off :
                                is_j  ? {pc4[31:28], ins[25:0], 2'b00} :
                                        pc4;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            IdExValid    <= 1'b0;
            IdExRegWrite <= 1'b0;
            IdExMemRead  <= 1'b0;
            IdExMemWrite <= 1'b0;
            IdExIllegal  <= 1'b0;
            IdExOp       <= 6'd0;
            IdExFunct    <= 6'd0;
            IdExDest     <= 5'd0;
            IdExRsVal    <= 32'd0;
            IdExRtVal    <= 32'd0;
            IdExImm      <= 32'd0;
        end else if (stall || fetch.Flush) begin
            IdExValid    <= 1'b0;
            IdExRegWrite <= 1'b0;
            IdExMemRead  <= 1'b0;
            IdExMemWrite <= 1'b0;
            IdExIllegal  <= 1'b0;
            IdExOp       <= 6'd0;
            IdExFunct    <= 6'd0;
            IdExDest     <= 5'd0;
            IdExRsVal    <= 32'd0;
            IdExRtVal    <= 32'd0;
            IdExImm      <= 32'd0;
        end else begin
            IdExValid    <= 1'b1;
            IdExRegWrite <= dec_wr;
            IdExMemRead  <= dec_mrd;
            IdExMemWrite <= dec_mwr;
            IdExIllegal  <= dec_ill;
            IdExOp       <= op;
            IdExFunct    <= ins[5:0];
            IdExDest     <= dec_dest;
            IdExRsVal    <= RsData;
            IdExRtVal    <= RtData;
            IdExImm      <= dec_imm;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            StallCount <= 16'd0;
        else if (stall && (StallCount != 16'hFFFF))
            StallCount <= StallCount + 16'd1;
    end
endmodule

// File: tb/tb_idecode_stage.sv
// Randomized bench for idecode_stage against a table-driven pipeline model.
module tb_idecode_stage;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  RsAddr, RtAddr, MemDest;
    logic [31:0] RsData, RtData;
    logic        MemRegWrite, MemIsLoad;
    logic        IdExValid, IdExRegWrite, IdExMemRead;
    logic        IdExMemWrite, IdExIllegal;
    logic [5:0]  IdExOp, IdExFunct;
    logic [4:0]  IdExDest;
    logic [31:0] IdExRsVal, IdExRtVal, IdExImm;
    logic [15:0] StallCount;

    idecode_stage_if fif ();

    idecode_stage dut (
        .Clk(Clk), .Reset_n(Reset_n), .fetch(fif),
        .RsAddr(RsAddr), .RtAddr(RtAddr),
        .RsData(RsData), .RtData(RtData),
        .MemDest(MemDest), .MemRegWrite(MemRegWrite),
        .MemIsLoad(MemIsLoad),
        .IdExValid(IdExValid), .IdExRegWrite(IdExRegWrite),
        .IdExMemRead(IdExMemRead), .IdExMemWrite(IdExMemWrite),
        .IdExIllegal(IdExIllegal), .IdExOp(IdExOp),
        .IdExFunct(IdExFunct), .IdExDest(IdExDest),
        .IdExRsVal(IdExRsVal), .IdExRtVal(IdExRtVal),
        .IdExImm(IdExImm), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // opcode property tables
    logic       t_legal[64];
    logic [1:0] t_dk[64];
    logic       t_wr[64], t_mrd[64], t_mwr[64];
    logic [1:0] t_src[64];

    task automatic tab(input int op, input logic [1:0] dk,
                       input logic wr, input logic mrd,
                       input logic mwr, input logic [1:0] src);
        t_legal[op] = 1'b1;
        t_dk[op] = dk;
        t_wr[op] = wr;
        t_mrd[op] = mrd;
        t_mwr[op] = mwr;
        t_src[op] = src;
    endtask

    // stimulus
    logic [31:0] f_ins, f_pc, f_rsd, f_rtd;
    logic        f_fl, f_mw, f_ml, auto_mem;
    logic [4:0]  f_md;

    // model ID/EX state and the stage after it
    logic        m_valid, m_wr, m_mrd, m_mwr, m_ill;
    logic [5:0]  m_op, m_fn;
    logic [4:0]  m_dest, p_dest;
    logic        p_wr, p_mrd;
    logic [31:0] m_rsv, m_rtv, m_imm;
    int          m_cnt;
    logic        e_stall, e_taken;
    logic [31:0] e_target;

    task automatic model_clear();
        {m_valid, m_wr, m_mrd, m_mwr, m_ill} = '0;
        m_op = 0; m_fn = 0; m_dest = 0;
        m_rsv = 0; m_rtv = 0; m_imm = 0;
    endtask

    task automatic model_comb();
        int op, rs, rt;
        logic ur, ut, lu, bh;
        op = int'(f_ins[31:26]);
        rs = int'(f_ins[25:21]);
        rt = int'(f_ins[20:16]);
        ur = t_legal[op] && t_src[op][0];
        ut = t_legal[op] && t_src[op][1];
        lu = m_mrd && m_dest != 0 &&
             ((ur && rs == int'(m_dest)) || (ut && rt == int'(m_dest)));
        bh = (op == 4 || op == 5) &&
             ((m_wr && m_dest != 0 &&
               (rs == int'(m_dest) || rt == int'(m_dest))) ||
              (f_ml && f_mw && f_md != 0 &&
               (rs == int'(f_md) || rt == int'(f_md))));
        e_stall = !f_fl && (lu || bh);
        e_taken = !f_fl && !e_stall &&
                  (op == 2 || (op == 4 && f_rsd == f_rtd) ||
                   (op == 5 && f_rsd != f_rtd));
        if (op == 4 || op == 5)
            e_target = f_pc + 4 +
                       32'($signed(f_ins[15:0])) * 4;
        else if (op == 2)
            e_target = ((f_pc + 4) & 32'hF000_0000) |
                       ((f_ins & 32'h03FF_FFFF) << 2);
        else
            e_target = f_pc + 4;
    endtask

    task automatic model_seq();
        int op;
        op = int'(f_ins[31:26]);
        p_dest = m_dest; p_wr = m_wr; p_mrd = m_mrd;
        if (e_stall && m_cnt < 65535) m_cnt++;
        model_clear();
        if (!e_stall && !f_fl) begin
            m_valid = 1'b1;
            m_op = f_ins[31:26];
            m_fn = f_ins[5:0];
            m_rsv = f_rsd;
            m_rtv = f_rtd;
            m_imm = (op == 'h0F) ? {f_ins[15:0], 16'h0}
                                 : 32'($signed(f_ins[15:0]));
            if (!t_legal[op]) m_ill = 1'b1;
            else begin
                m_wr  = t_wr[op] && (f_ins != 0);
                m_mrd = t_mrd[op];
                m_mwr = t_mwr[op];
                m_dest = (t_dk[op] == 1) ? f_ins[15:11] :
                         (t_dk[op] == 2) ? f_ins[20:16] : 5'd0;
            end
        end
    endtask

    task automatic apply();
        if (auto_mem) begin
            f_md = p_dest; f_mw = p_wr; f_ml = p_mrd;
        end
        fif.Fetched = f_ins; fif.FetchedPC = f_pc; fif.Flush = f_fl;
        RsData = f_rsd; RtData = f_rtd;
        MemDest = f_md; MemRegWrite = f_mw; MemIsLoad = f_ml;
    endtask

    task automatic check_regs();
        check("valid", 32'(IdExValid), 32'(m_valid));
        check("regwr", 32'(IdExRegWrite), 32'(m_wr));
        check("memrd", 32'(IdExMemRead), 32'(m_mrd));
        check("memwr", 32'(IdExMemWrite), 32'(m_mwr));
        check("illegal", 32'(IdExIllegal), 32'(m_ill));
        check("op", 32'(IdExOp), 32'(m_op));
        check("funct", 32'(IdExFunct), 32'(m_fn));
        check("dest", 32'(IdExDest), 32'(m_dest));
        check("rsval", IdExRsVal, m_rsv);
        check("rtval", IdExRtVal, m_rtv);
        check("imm", IdExImm, m_imm);
        check("stallcnt", 32'(StallCount), 32'(m_cnt));
    endtask

    // one decode cycle, entered and left at posedge+1
    task automatic cyc();
        apply();
        #1;
        model_comb();
        check("stall", 32'(fif.Stall), 32'(e_stall));
        check("taken", 32'(fif.BranchTaken), 32'(e_taken));
        check("target", fif.BranchTarget, e_target);
        check("rsaddr", 32'(RsAddr), 32'(f_ins[25:21]));
        check("rtaddr", 32'(RtAddr), 32'(f_ins[20:16]));
        @(posedge Clk);
        model_seq();
        #1;
        check_regs();
    endtask

    task automatic set(input logic [31:0] ins, input logic [31:0] pc);
        f_ins = ins; f_pc = pc;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        set(0, 0);
        f_fl = 0; f_rsd = 0; f_rtd = 0;
        model_clear();
        m_cnt = 0; p_dest = 0; p_wr = 0; p_mrd = 0;
        apply();
        @(posedge Clk);
        #1;
        check("rst_valid", 32'(IdExValid), 0);
        check("rst_cnt", 32'(StallCount), 0);
        Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            t_legal[i] = 0; t_dk[i] = 0; t_wr[i] = 0;
            t_mrd[i] = 0; t_mwr[i] = 0; t_src[i] = 0;
        end
        tab('h00, 1, 1, 0, 0, 3);
        tab('h08, 2, 1, 0, 0, 1);
        tab('h0A, 2, 1, 0, 0, 1);
        tab('h0C, 2, 1, 0, 0, 1);
        tab('h0D, 2, 1, 0, 0, 1);
        tab('h0F, 2, 1, 0, 0, 1);
        tab('h23, 2, 1, 1, 0, 1);
        tab('h2B, 0, 0, 0, 1, 3);
        tab('h04, 0, 0, 0, 0, 3);
        tab('h05, 0, 0, 0, 0, 3);
        tab('h02, 0, 0, 0, 0, 0);
        auto_mem = 1'b1;
        f_md = 0; f_mw = 0; f_ml = 0;

        // reset with random instructions present
        do_reset();
        Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_ins = $urandom; f_pc = $urandom;
            apply();
            @(posedge Clk);
            #1;
            check_regs();
        end
        set(0, 0);
        Reset_n = 1'b1;
        cyc();
        check("rel_valid", 32'(IdExValid), 1);
        check("rel_regwr", 32'(IdExRegWrite), 0);

        // load-use
        do_reset();
        set(32'h8C22_0000, 0); cyc();
        set(32'h0044_1820, 4); cyc();
        check("lu_bubble", 32'(IdExValid), 0);
        cyc();
        check("lu_dest", 32'(IdExDest), 3);
        check("lu_wr", 32'(IdExRegWrite), 1);
        check("lu_cnt", 32'(StallCount), 1);

        // taken / not-taken beq
        do_reset();
        set(32'h1021_0003, 32'h100); f_rsd = 5; f_rtd = 5;
        apply(); #1;
        check("beq_taken", 32'(fif.BranchTaken), 1);
        check("beq_tgt", fif.BranchTarget, 32'h110);
        f_rtd = 6; apply(); #1;
        check("beq_nt", 32'(fif.BranchTaken), 0);
        cyc();

        // branch after load
        do_reset();
        f_rsd = 7; f_rtd = 7;
        set(32'h8C01_0000, 0); cyc();
        set(32'h1021_0003, 4);
        for (int i = 0; i < 2; i++) begin
            apply(); #1;
            check("bl_stall", 32'(fif.Stall), 1);
            check("bl_nt", 32'(fif.BranchTaken), 0);
            cyc();
        end
        apply(); #1;
        check("bl_taken", 32'(fif.BranchTaken), 1);
        cyc();
        check("bl_cnt", 32'(StallCount), 2);

        // jump and immediates
        do_reset();
        set(32'h0800_0010, 32'h100); apply(); #1;
        check("j_tgt", fif.BranchTarget, 32'h40);
        cyc();
        set(32'h2005_FFFF, 0); cyc();
        check("addi_imm", IdExImm, 32'hFFFF_FFFF);
        check("addi_dest", 32'(IdExDest), 5);
        set(32'h3C01_1234, 0); cyc();
        check("lui_imm", IdExImm, 32'h1234_0000);

        // illegal op, flush over a hazard
        set(32'hFC00_0000, 0); cyc();
        check("ill", 32'(IdExIllegal), 1);
        check("ill_wr", 32'(IdExRegWrite), 0);
        set(32'h8C02_0000, 0); cyc();
        set(32'h0044_1820, 4); f_fl = 1; apply(); #1;
        check("fl_stall", 32'(fif.Stall), 0);
        cyc();
        check("fl_bubble", 32'(IdExValid), 0);
        f_fl = 0;

        // reset asserted in the middle of a load-use stall
        do_reset();
        set(32'h8C22_0000, 0); cyc();
        set(32'h0044_1820, 4); apply(); #1;
        check("mr_stall", 32'(fif.Stall), 1);
        Reset_n = 1'b0; #1;
        check("mr_memrd", 32'(IdExMemRead), 0);
        check("mr_nostall", 32'(fif.Stall), 0);
        model_clear(); m_cnt = 0; p_dest = 0; p_wr = 0; p_mrd = 0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        cyc();
        check("mr_after", 32'(IdExDest), 3);

        // randomized traffic
        do_reset();
        auto_mem = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] ops [13];
            ops = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                    6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h01};
            if (!e_stall) begin
                f_ins = {ops[$urandom_range(0, 12)],
                         5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)), 16'($urandom)};
                if ($urandom_range(0, 15) == 0) f_ins = 0;
                f_pc = $urandom & 32'hFFFF_FFFC;
            end
            f_fl  = ($urandom_range(0, 15) == 0);
            f_rsd = $urandom;
            f_rtd = $urandom_range(0, 1) ? f_rsd : $urandom;
            f_md  = 5'($urandom_range(0, 3));
            f_mw  = 1'($urandom);
            f_ml  = 1'($urandom);
            cyc();
        end

        // saturating stall counter
        do_reset();
        set(32'h1021_0003, 0);
        f_fl = 0; f_md = 1; f_mw = 1; f_ml = 1;
        for (int i = 0; i < 70000; i++) cyc();
        check("sat_cnt", 32'(StallCount), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idecode_stage.md
# idecode_stage

Instruction decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage. It decodes the fetch stage's registered instruction (the IF/ID register) combinationally and reads register operands. It detects load-use and branch-operand hazards and drives `Stall` back to fetch. It resolves `beq`/`bne`/`j` in ID and drives `BranchTaken`/`BranchTarget`, and loads the ID/EX pipeline register, inserting bubbles when stalled.

## Interface
- `NOP`, 32'h0000_0000, encoding treated as no-operation (also emitted by fetch during flush/branch discard)
- `Clk` in 1: rising-edge clock
- `Reset_n` in 1: asynchronous, active-low reset
- `Fetched` in 32: instruction from fetch (IF/ID register)
- `FetchedPC` in 32: address of `Fetched`
- `Flush` in 1: fetch start-up flush; forces decode of a NOP
- `RsAddr`, `RtAddr` out 5: register file read addresses, `Fetched[25:21]`, `Fetched[20:16]`
- `RsData`, `RtData` in 32: combinational register file read data
- `MemDest` in 5, `MemRegWrite` in 1, `MemIsLoad` in 1: EX/MEM destination info
- `Stall` out 1: combinational; fetch holds `Fetched`
- `BranchTaken` out 1, `BranchTarget` out 32: combinational redirect
- `IdExValid`, `IdExRegWrite`, `IdExMemRead`, `IdExMemWrite`, `IdExIllegal` out 1 each: registered controls
- `IdExOp` out 6, `IdExFunct` out 6, `IdExDest` out 5: registered fields
- `IdExRsVal`, `IdExRtVal`, `IdExImm` out 32: registered operands and sign-extended immediate (`lui`: `{imm,16'h0}`)
- `StallCount` out 16: saturating count of stall cycles

## Operation
- Decode classes, keyed by `op = Fetched[31:26]`:
  - R-type `0x00`: dest rd, RegWrite. `Fetched==NOP` is a NOP.
  - `addi 08`, `slti 0A`, `andi 0C`, `ori 0D`, `lui 0F`: dest rt, RegWrite.
  - `lw 23`: dest rt, RegWrite, MemRead.
  - `sw 2B`: MemWrite, no dest.
  - `beq 04`, `bne 05`, `j 02`: no dest, no memory.
  - Any other op: Valid=1, all controls 0, Illegal=1.
- Sources: R-type, `sw`, `beq` and `bne` use rs and rt. I-type ALU ops and `lw` use rs only. `j` uses none. Register 0 never creates a hazard.
- Load-use hazard: `IdExMemRead && IdExDest!=0 && IdExDest` matches a used source → `Stall=1`.
- Branch-operand hazard (`beq`/`bne` only; there is no forwarding into ID):
  - `IdExRegWrite` with `IdExDest` matching rs or rt → `Stall=1`.
  - `MemIsLoad && MemRegWrite` with `MemDest` matching rs or rt → `Stall=1`.
- While `Flush=1`, `Stall=0` and `BranchTaken=0`.
- Branch resolution, only when `Stall=0`:
  - `beq`: taken iff `RsData==RtData`.
  - `bne`: taken iff `RsData!=RtData`.
  - `j`: always taken.
- `BranchTarget` (32-bit wrap arithmetic, carries discarded):
  - `beq`/`bne`: `FetchedPC+4+(sext(imm16)<<2)`.
  - `j`: `{(FetchedPC+4)[31:28], Fetched[25:0], 2'b00}`.
  - Otherwise `BranchTarget` = `FetchedPC+4`.
- ID/EX register, updated each posedge:
  - `Stall=1` or `Flush=1`: load a bubble (all IdEx outputs 0).
  - Otherwise: load the decoded instruction with `IdExValid=1`. A NOP decodes to Valid=1 with all controls 0.
- A taken branch itself enters ID/EX normally (Valid=1, no write). Discarding the following instruction is fetch's job.
- `StallCount` increments on each posedge with `Stall=1` and saturates at 16'hFFFF.

## Timing
- `Reset_n=0` (asynchronous): all IdEx outputs 0 and `StallCount=0`. The combinational outputs follow `Fetched` (fetch supplies NOPs during reset).
- Decode-to-ID/EX latency: 1 cycle.
- `Stall`, `BranchTaken` and `BranchTarget` are valid before the posedge at which fetch samples them.
- A load followed by a dependent ALU op costs exactly 1 stall cycle.
- A load followed by a dependent branch costs 2 stall cycles. An ALU op followed by a dependent branch costs 1.
- Stall and branch are never asserted together. A stalled branch resolves on the cycle its hazard clears.
- If reset is asserted mid-stall, the next cycle after release shows `Stall=0` (ID/EX empty).

## Test plan
- Reset: hold `Reset_n=0` with random `Fetched` → all IdEx outputs 0 and `StallCount=0`. Release with `Fetched=0` → `IdExValid=1`, controls 0.
- Load-use: `lw $2,0($1)` (8C220000) then `add $3,$2,$4` (00441820) → `Stall=1` for one cycle and one bubble in ID/EX. The add then enters with `IdExDest=3` and `IdExRegWrite=1`. `StallCount=1`.
- Taken branch: `beq $1,$1,+3` (10210003) at PC 0x100 with `RsData=RtData=5` → `BranchTaken=1`, `BranchTarget=0x110`. With `RtData=6` → `BranchTaken=0`.
- Branch after load: `lw $1` followed by `beq $1,$1` → `Stall` for 2 cycles, no `BranchTaken` while stalled, branch taken on cycle 3. `StallCount=2`.
- Jump and immediates:
  - `j 0x10` (08000010) at PC 0x100 → `BranchTarget=0x40`.
  - `addi $5,$0,-1` (2005FFFF) → `IdExImm=0xFFFFFFFF`, `IdExDest=5`.
  - `lui` with imm 0x1234 → `IdExImm=0x12340000`.
- Illegal op and flush: op 0x3F → `IdExIllegal=1`, `IdExRegWrite=0`. `Flush=1` with a hazard present → `Stall=0` and an ID/EX bubble. Forcing `Stall` for 70000 cycles → `StallCount` holds at 0xFFFF.
